voting_ballot_collector: RTL
============================

// Module: voting_ballot_collector
// PURPOSE
//  Upstream feeder for the combinational MPC voting evaluators (e.g. 8-input, 1-bit-result voting netlists).
//  Accepts ballot slots one at a time over a valid/ready stream and packs them into the flat p_input vector.
//  Holds that vector stable for the evaluator, samples its 1-bit result and returns it over a valid/ready result port.
//  Also keeps a saturating count of completed elections.
// PARAMETERS
//  SLOT_W    4  bits per ballot slot (one stream beat)
//  NUM_SLOTS 2  slots per election; VEC_W = SLOT_W*NUM_SLOTS (default 8, matches 8-input evaluator)
//  EVAL_LAT  1  cycles p_input is held before eval_o is sampled (>=1; covers evaluator settle time)
//  CNT_W     8  width of the election counter
// PORTS
//  clk        in   1          single clock, all state on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          begin new election (honoured only in IDLE)
//  abort      in   1          cancel election in progress
//  in_valid   in   1          ballot slot valid
//  in_ready   out  1          collector can accept a slot
//  in_data    in   SLOT_W     ballot slot payload
//  p_input    out  VEC_W      packed vector to evaluator; slot i at bits [i*SLOT_W +: SLOT_W]
//  eval_o     in   1          evaluator result (combinational from p_input)
//  res_valid  out  1          result available
//  res_ready  in   1          consumer accepts result
//  res_winner out  1          registered eval_o
//  elect_cnt  out  CNT_W      completed elections, saturates at all-ones
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; p_input, res_winner, elect_cnt, slot idx, latency cnt = 0; in_ready=res_valid=busy=0.
//  States: IDLE -> COLLECT -> EVAL -> RESULT -> IDLE.
//  IDLE: in_ready=0. start=1 (and abort=0) -> COLLECT; p_input cleared to 0, idx=0 at same edge.
//  COLLECT: in_ready=1 (registered-state decode, no combinational path from in_valid).
//   Beat accepted on in_valid&in_ready: p_input slot[idx] <= in_data, idx++.
//   Accept of slot NUM_SLOTS-1 -> EVAL, latency cnt=0. No idle-cycle penalty between beats.
//  EVAL: in_ready=0; p_input constant. cnt counts to EVAL_LAT; on the edge where cnt==EVAL_LAT-1 capture
//   res_winner<=eval_o and -> RESULT. res_valid thus rises EVAL_LAT cycles after final-beat edge.
//  RESULT: res_valid=1, res_winner stable; held until res_ready=1; on handshake -> IDLE,
//   elect_cnt += 1 unless already all-ones. p_input retained in IDLE until next start.
//  abort: in COLLECT or EVAL -> IDLE at next edge, p_input cleared, no result, elect_cnt unchanged;
//   abort beats a same-cycle in handshake (beat discarded). abort ignored in RESULT and IDLE.
//  start outside IDLE ignored; start&abort in IDLE -> stay IDLE.
//  in_valid while in_ready=0: no effect, data not consumed.
//  Reset mid-operation: immediate return to reset values; partially packed vector lost.
// TESTING (defaults SLOT_W=4, NUM_SLOTS=2, EVAL_LAT=1)
//  1 start; beats 0x3,0xB back-to-back; eval_o=1 -> p_input=8'hB3 after 2nd beat; res_valid 1 cycle later, res_winner=1;
//    res_ready=1 -> IDLE, elect_cnt=1.
//  2 res_ready held 0 for 5 cycles in RESULT -> res_valid, res_winner, p_input stable all 5 cycles; no counter change.
//  3 start; beat 0x5; abort with in_valid=1,in_data=0xF -> IDLE, p_input=0, res_valid never asserted, elect_cnt unchanged.
//  4 in_valid=1 toggled with gaps (beat, 3 idle, beat) -> exactly 2 slots packed in order; in_ready=0 in EVAL ignores extra beats.
//  5 CNT_W=2 run 5 elections -> elect_cnt 1,2,3,3,3 (saturation).
//  6 rst_n low mid-COLLECT (asynchronously, between edges) -> all outputs 0 immediately; start after release runs clean election.

Source files
------------

// File: rtl/voting_ballot_collector.sv
// rtl/voting_ballot_collector.sv - packs ballot slots for an MPC voting evaluator and returns its result
module voting_ballot_collector #(
  parameter  int SLOT_W    = 4,
  parameter  int NUM_SLOTS = 2,
  parameter  int EVAL_LAT  = 1,
  parameter  int CNT_W     = 8,
  localparam int VEC_W     = SLOT_W * NUM_SLOTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SLOT_W-1:0] in_data,
  output logic [VEC_W-1:0]  p_input,
  input  logic              eval_o,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_winner,
  output logic [CNT_W-1:0]  elect_cnt,
  output logic              busy
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int LAT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, RESULT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [LAT_W-1:0]  lat_q;
  logic              last_slot;
  logic              lat_done;

  assign last_slot = (idx_q == IDX_W'(NUM_SLOTS - 1));
  assign lat_done  = (lat_q == LAT_W'(EVAL_LAT - 1));

  // Handshake outputs decode registered state only, so in_ready never depends on in_valid.
  assign in_ready  = (state_q == COLLECT);
  assign res_valid = (state_q == RESULT);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = COLLECT;
      COLLECT: begin
        if (abort)                       state_d = IDLE;
        else if (in_valid && last_slot)  state_d = EVAL;
      end
      EVAL: begin
        if (abort)         state_d = IDLE;
        else if (lat_done) state_d = RESULT;
      end
      RESULT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_input    <= '0;
      res_winner <= 1'b0;
      elect_cnt  <= '0;
      idx_q      <= '0;
      lat_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            p_input <= '0;
            idx_q   <= '0;
          end
        end
        COLLECT: begin
          // abort wins over a same-cycle beat; that beat is dropped.
          if (abort) begin
            p_input <= '0;
            idx_q   <= '0;
          end else if (in_valid) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (idx_q == IDX_W'(i)) p_input[i*SLOT_W +: SLOT_W] <= in_data;
            end
            if (last_slot) begin
              idx_q <= '0;
              lat_q <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        EVAL: begin
          if (abort)         p_input    <= '0;
          else if (lat_done) res_winner <= eval_o;
          else               lat_q      <= lat_q + 1'b1;
        end
        RESULT: begin
          if (res_ready && (elect_cnt != {CNT_W{1'b1}})) elect_cnt <= elect_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
